// File: rtl/f_fetch_seq.sv
// Fetch-stage sequencer: owns the F-stage PC, runs one-outstanding imem req/gnt/rvalid, presents F_pc/F_instr/F_valid.
// Latency: zero-wait memory yields one instruction every 2 cycles (ISSUE, HAVE); F_valid rises on the rdata capture edge.
// Backpressure: D_stall freezes the presented fetch in HAVE; npc is sampled only on a consume cycle (HAVE & !D_stall).
module f_fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        D_stall,
    input  logic [31:0] npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] F_pc,
    output logic [31:0] F_instr,
    output logic        F_valid,
    output logic        F_adel,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HAVE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        adel_q;
    logic [31:0] cnt_q;

    logic        pc_misaligned;
    logic        capture;
    logic        fault;
    logic        consume;

    assign pc_misaligned = (pc_q[1:0] != 2'b00);

    // State register; reset abandons any fetch in flight and restarts from BOOT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; rvalid only matters in WAIT or alongside gnt in ISSUE.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:  state_nxt = ISSUE;
            ISSUE: begin
                if (pc_misaligned) begin
                    state_nxt = HAVE;
                end else if (imem_gnt && imem_rvalid) begin
                    state_nxt = HAVE;
                end else if (imem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT:  if (imem_rvalid) state_nxt = HAVE;
            HAVE:  if (!D_stall) state_nxt = ISSUE;
            default: state_nxt = BOOT;
        endcase
    end

    // Output and strobe decode; imem_addr comes from pc_q only, so npc never reaches it combinationally.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        capture   = 1'b0;
        fault     = 1'b0;
        consume   = 1'b0;
        case (state)
            ISSUE: begin
                imem_req = !pc_misaligned;
                fault    = pc_misaligned;
                capture  = !pc_misaligned && imem_gnt && imem_rvalid;
            end
            WAIT:    capture = imem_rvalid;
            HAVE:    consume = !D_stall;
            default: ;
        endcase
    end

    // F-stage datapath: capture the fetched word (or NOP on a fault), advance PC and count on consume.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            if (capture) begin
                instr_q <= imem_rdata;
                valid_q <= 1'b1;
                adel_q  <= 1'b0;
            end else if (fault) begin
                instr_q <= NOP_WORD;
                valid_q <= 1'b1;
                adel_q  <= 1'b1;
            end else if (consume) begin
                pc_q    <= npc;
                valid_q <= 1'b0;
                adel_q  <= 1'b0;
                cnt_q   <= cnt_q + 32'd1;
            end
        end
    end

    assign F_pc      = pc_q;
    assign F_instr   = instr_q;
    assign F_valid   = valid_q;
    assign F_adel    = adel_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_f_fetch_seq.sv
// Bench for f_fetch_seq: directed scenarios plus a randomized run against a transaction-level model.
// Inputs are driven and outputs sampled 1ns after each rising edge.
// The memory responder randomizes grant/response latency and injects stray responses.
module tb_f_fetch_seq;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        D_stall;
    logic [31:0] npc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] F_pc;
    logic [31:0] F_instr;
    logic        F_valid;
    logic        F_adel;
    logic [31:0] fetch_cnt;

    int checks   = 0;
    int failures = 0;

    f_fetch_seq #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
        .clk        (clk),
        .reset      (reset),
        .D_stall    (D_stall),
        .npc        (npc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .F_pc       (F_pc),
        .F_instr    (F_instr),
        .F_valid    (F_valid),
        .F_adel     (F_adel),
        .fetch_cnt  (fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        D_stall     = 1'b0;
        npc         = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    // Hold reset for two cycles, release 1ns after an edge: the current cycle is then BOOT.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (F_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", F_valid); end
        checks++; if (F_adel !== 1'b0) begin failures++; $display("FAIL reset_adel got=%b exp=0", F_adel); end
        checks++; if (F_pc !== RST_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", F_pc, RST_PC); end
        checks++; if (F_instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", F_instr, NOP); end
        checks++; if (fetch_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", fetch_cnt); end
        reset = 1'b1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL boot_req got=%b exp=0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            failures++; $display("FAIL first_req got=%b/%h exp=1/%h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        do_reset();
        tick();
        imem_gnt = 1'b1;
        imem_rvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = RST_PC + 32'(4 * (i / 2));
            checks++; if (F_valid !== 1'(i % 2) || fetch_cnt !== 32'(i / 2)) begin
                failures++; $display("FAIL zw_valid_cnt cyc=%0d got=%b/%0d exp=%0d/%0d", i, F_valid, fetch_cnt, i % 2, i / 2);
            end
            if (i % 2 == 0) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin
                    failures++; $display("FAIL zw_req cyc=%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, a);
                end
            end else begin
                checks++; if (imem_req !== 1'b0 || F_pc !== a || F_instr !== mem_word(a)) begin
                    failures++; $display("FAIL zw_have cyc=%0d got=%b/%h/%h exp=0/%h/%h", i, imem_req, F_pc, F_instr, a, mem_word(a));
                end
            end
            imem_rdata = mem_word(a);
            npc = a + 32'd4;
            tick();
        end
        checks++; if (fetch_cnt !== 32'd3) begin failures++; $display("FAIL zw_cnt got=%0d exp=3", fetch_cnt); end
    endtask

    // Grant after 3 idle cycles, data 2 cycles after grant; continues into the stall and misaligned scenarios.
    task automatic test_delayed_grant();
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
                failures++; $display("FAIL dg_hold cyc=%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, RST_PC);
            end
            imem_gnt = (i == 3);
            tick();
        end
        imem_gnt = 1'b0;
        checks++; if (imem_req !== 1'b0 || F_valid !== 1'b0) begin
            failures++; $display("FAIL dg_wait got=%b/%b exp=0/0", imem_req, F_valid);
        end
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        checks++; if (F_valid !== 1'b0) begin failures++; $display("FAIL dg_early_valid got=%b exp=0", F_valid); end
        tick();
        imem_rvalid = 1'b0;
        checks++; if (F_valid !== 1'b1 || F_instr !== 32'hCAFE_F00D || F_pc !== RST_PC) begin
            failures++; $display("FAIL dg_capture got=%b/%h/%h exp=1/cafef00d/%h", F_valid, F_instr, F_pc, RST_PC);
        end
    endtask

    task automatic test_stall();
        logic [31:0] r;
        for (int i = 0; i < 5; i++) begin
            r = $urandom;
            D_stall     = 1'b1;
            npc         = {r[31:2], 2'b00};
            imem_rvalid = r[0];
            imem_rdata  = ~r;
            tick();
            checks++; if (F_valid !== 1'b1 || F_pc !== RST_PC || F_instr !== 32'hCAFE_F00D || imem_req !== 1'b0 || fetch_cnt !== 32'd0) begin
                failures++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%h/%b/%0d", i, F_valid, F_pc, F_instr, imem_req, fetch_cnt);
            end
        end
        D_stall     = 1'b0;
        imem_rvalid = 1'b0;
        npc         = 32'h0000_5A5C;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_5A5C || F_valid !== 1'b0 || fetch_cnt !== 32'd1) begin
            failures++; $display("FAIL stall_release got=%b/%h/%b/%0d exp=1/00005a5c/0/1", imem_req, imem_addr, F_valid, fetch_cnt);
        end
    endtask

    task automatic test_misaligned();
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(32'h0000_5A5C);
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        npc         = 32'h0000_3002;
        tick();
        checks++; if (imem_req !== 1'b0 || F_valid !== 1'b0) begin
            failures++; $display("FAIL mis_issue got=%b/%b exp=0/0", imem_req, F_valid);
        end
        npc = 32'h0000_3008;
        tick();
        checks++; if (F_valid !== 1'b1 || F_adel !== 1'b1 || F_instr !== NOP || F_pc !== 32'h0000_3002 || imem_req !== 1'b0) begin
            failures++; $display("FAIL mis_have got=%b/%b/%h/%h/%b exp=1/1/%h/00003002/0", F_valid, F_adel, F_instr, F_pc, imem_req, NOP);
        end
        tick();
        checks++; if (F_adel !== 1'b0 || F_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_3008) begin
            failures++; $display("FAIL mis_after got=%b/%b/%b/%h exp=0/0/1/00003008", F_adel, F_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || F_valid !== 1'b0 || F_pc !== RST_PC || fetch_cnt !== 32'd0 || F_instr !== NOP) begin
            failures++; $display("FAIL rst_async got=%b/%b/%h/%0d/%h", imem_req, F_valid, F_pc, fetch_cnt, F_instr);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC || F_valid !== 1'b0) begin
            failures++; $display("FAIL rst_first_req got=%b/%h/%b exp=1/%h/0", imem_req, imem_addr, F_valid, RST_PC);
        end
        tick();
        checks++; if (F_valid !== 1'b0 || imem_req !== 1'b1) begin
            failures++; $display("FAIL rst_stray got=%b/%b exp=0/1", F_valid, imem_req);
        end
        imem_gnt   = 1'b1;
        imem_rdata = mem_word(RST_PC);
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        checks++; if (F_valid !== 1'b1 || F_instr !== mem_word(RST_PC)) begin
            failures++; $display("FAIL rst_fetch got=%b/%h exp=1/%h", F_valid, F_instr, mem_word(RST_PC));
        end
    endtask

    task automatic test_count_wrap();
        D_stall = 1'b1;
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        D_stall = 1'b0;
        npc     = 32'h0000_3010;
        tick();
        checks++; if (fetch_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_max got=%h exp=ffffffff", fetch_cnt); end
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(32'h0000_3010);
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        npc         = 32'h0000_3014;
        tick();
        checks++; if (fetch_cnt !== 32'h0000_0000) begin failures++; $display("FAIL wrap_zero got=%h exp=00000000", fetch_cnt); end
    endtask

    // Transaction-level model: track the PC the next presented fetch must carry, the consume count,
    // and which responder events (completion, stall, misaligned issue) make F_valid true next cycle.
    task automatic test_random();
        logic [31:0] epc, ecnt, lnpc, paddr, r;
        logic granted, pending, ev, mis, ereq, lhold, lcomp, lcons, lmis;
        int k, dly, idle;
        do_reset();
        epc = RST_PC; ecnt = 0; k = 0; granted = 0; pending = 0; dly = 0; paddr = 0;
        lhold = 0; lcomp = 0; lcons = 0; lmis = 0; lnpc = 0; idle = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) begin
                if (lcons) begin
                    epc = lnpc; ecnt = ecnt + 1; k = 1; granted = 0;
                end else begin
                    k++;
                end
            end
            mis  = (epc[1:0] != 2'b00);
            ev   = lhold | lcomp | lmis;
            ereq = !ev && !mis && (k >= 1) && !granted;
            checks++; if (F_valid !== ev || fetch_cnt !== ecnt || imem_req !== ereq) begin
                failures++; $display("FAIL rnd_ctl cyc=%0d valid=%b/%b cnt=%0d/%0d req=%b/%b", cyc, F_valid, ev, fetch_cnt, ecnt, imem_req, ereq);
            end
            if (ev) begin
                checks++; if (F_pc !== epc || F_adel !== mis || F_instr !== (mis ? NOP : mem_word(epc))) begin
                    failures++; $display("FAIL rnd_data cyc=%0d pc=%h/%h adel=%b/%b instr=%h", cyc, F_pc, epc, F_adel, mis, F_instr);
                end
            end
            if (ereq) begin
                checks++; if (imem_addr !== epc) begin
                    failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, epc);
                end
            end
            r = $urandom;
            D_stall = r[0] & r[1];
            npc = {16'h0001, r[15:2], 2'b00};
            if (r[20:18] == 3'd0) npc[1:0] = r[17:16] | 2'b01;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            lcomp = 1'b0;
            if (pending) begin
                if (dly == 0) begin
                    imem_rvalid = 1'b1; imem_rdata = mem_word(paddr); pending = 1'b0; lcomp = 1'b1;
                end else begin
                    dly--;
                end
            end else if (ereq && r[4:3] != 2'b00) begin
                imem_gnt = 1'b1;
                granted  = 1'b1;
                if (r[5]) begin
                    imem_rvalid = 1'b1; imem_rdata = mem_word(epc); lcomp = 1'b1;
                end else begin
                    pending = 1'b1; dly = int'(r[7:6]); paddr = epc;
                end
            end else if (r[9:8] == 2'b00) begin
                imem_rvalid = 1'b1;
            end
            lhold = ev && D_stall;
            lcons = ev && !D_stall;
            lmis  = (k == 1) && mis;
            lnpc  = npc;
            idle  = lcons ? 0 : idle + 1;
            tick();
            if (idle > 60) begin
                failures++; checks++;
                $display("FAIL rnd_progress cyc=%0d no consume for %0d cycles", cyc, idle);
                break;
            end
        end
        checks++; if (ecnt < 32'd200) begin
            failures++; $display("FAIL rnd_volume consumed=%0d exp>=200", ecnt);
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_zero_wait();
        test_delayed_grant();
        test_stall();
        test_misaligned();
        test_reset_mid_fetch();
        test_count_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
